// File: rtl/fp_multiplier.sv
// Sequential IEEE-754 single-precision multiplier.
// Uses a shift-add significand product (one bit per cycle) and
// round-to-nearest-even. Denormals are flushed to zero on input and
// are never produced on output.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; operands are captured when it is seen
// UNPACK | decode operands; special operands finish here directly
// MUL    | 24 shift-add steps that build the 48-bit significand product
// NORM   | bring a product in [2,4) back to [1,2) and bump the exponent
// ROUND  | round to nearest even, check range, write result and flags
// DONE   | one-cycle done pulse, then back to IDLE
module fp_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        underflow,
    output logic        overflow,
    output logic        invalid_op
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MUL    = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t state;
    state_t state_next;

    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [47:0]        mcand;
    logic [23:0]        mplier;
    logic [47:0]        prod;
    logic [4:0]         bit_cnt;

    // Operand decode
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [22:0] frac_a;
    logic [22:0] frac_b;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        is_special;
    logic        prod_sign;
    logic signed [9:0] exp_sum;
    logic [31:0] spec_result;
    logic        spec_invalid;

    assign exp_a  = op_a[30:23];
    assign exp_b  = op_b[30:23];
    assign frac_a = op_a[22:0];
    assign frac_b = op_b[22:0];

    // exponent 0 covers both true zero and denormals (flushed to zero)
    assign a_zero = (exp_a == 8'd0);
    assign b_zero = (exp_b == 8'd0);
    assign a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);

    assign is_special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    assign prod_sign  = op_a[31] ^ op_b[31];
    assign exp_sum    = signed'({2'b00, exp_a}) + signed'({2'b00, exp_b}) - 10'sd127;

    // Result selection for zero / infinity / NaN operands
    always_comb begin
        spec_result  = {prod_sign, 31'd0};
        spec_invalid = 1'b0;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            spec_result  = QNAN;
            spec_invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_result = {prod_sign, 8'hFF, 23'd0};
        end
    end

    // Rounding of the normalised product (leading one at bit 46)
    logic        rnd_lsb, rnd_guard, rnd_round, rnd_sticky, round_up;
    logic [24:0] sig_rounded;
    logic [22:0] frac_final;
    logic signed [9:0] exp_final;
    logic [31:0] norm_result;
    logic        norm_overflow;
    logic        norm_underflow;

    assign rnd_lsb     = prod[23];
    assign rnd_guard   = prod[22];
    assign rnd_round   = prod[21];
    assign rnd_sticky  = |prod[20:0];
    assign round_up    = rnd_guard & (rnd_round | rnd_sticky | rnd_lsb);
    assign sig_rounded = {1'b0, prod[46:23]} + {24'd0, round_up};

    // Range check after rounding, including the renormalising carry-out
    always_comb begin
        frac_final     = sig_rounded[22:0];
        exp_final      = exp_r;
        if (sig_rounded[24]) begin
            frac_final = sig_rounded[23:1];
            exp_final  = exp_r + 10'sd1;
        end
        norm_overflow  = 1'b0;
        norm_underflow = 1'b0;
        norm_result    = {sign_r, exp_final[7:0], frac_final};
        if (exp_final >= 10'sd255) begin
            norm_overflow = 1'b1;
            norm_result   = {sign_r, 8'hFF, 23'd0};
        end else if (exp_final <= 10'sd0) begin
            norm_underflow = 1'b1;
            norm_result    = {sign_r, 31'd0};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = UNPACK;
            UNPACK:  state_next = is_special ? DONE : MUL;
            MUL:     if (bit_cnt == 5'd0) state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            sign_r     <= 1'b0;
            exp_r      <= 10'sd0;
            mcand      <= 48'd0;
            mplier     <= 24'd0;
            prod       <= 48'd0;
            bit_cnt    <= 5'd0;
            result     <= 32'd0;
            underflow  <= 1'b0;
            overflow   <= 1'b0;
            invalid_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a <= a;
                        op_b <= b;
                    end
                end
                UNPACK: begin
                    sign_r  <= prod_sign;
                    exp_r   <= exp_sum;
                    mcand   <= {24'd0, 1'b1, frac_a};
                    mplier  <= {1'b1, frac_b};
                    prod    <= 48'd0;
                    bit_cnt <= 5'd23;
                    if (is_special) begin
                        result     <= spec_result;
                        invalid_op <= spec_invalid;
                        overflow   <= 1'b0;
                        underflow  <= 1'b0;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt - 5'd1;
                end
                NORM: begin
                    // the dropped bit is folded into bit 0 so sticky survives
                    if (prod[47]) begin
                        prod  <= {1'b0, prod[47:2], prod[1] | prod[0]};
                        exp_r <= exp_r + 10'sd1;
                    end
                end
                ROUND: begin
                    result     <= norm_result;
                    overflow   <= norm_overflow;
                    underflow  <= norm_underflow;
                    invalid_op <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed-vector bench for fp_multiplier.
module tb_fp_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        underflow;
    logic        overflow;
    logic        invalid_op;

    int n_tests = 0;
    int n_fail  = 0;

    fp_multiplier dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .underflow  (underflow),
        .overflow   (overflow),
        .invalid_op (invalid_op)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one multiplication; lat counts rising edges from the start edge
    // up to and including the edge that enters DONE.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          output logic [31:0] res, output logic [2:0] flg,
                          output int lat);
        logic busy_seen;
        busy_seen = 1'b0;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        lat   = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                start     = 1'b0;
                busy_seen = busy;
            end
            if (done) break;
        end
        res = result;
        flg = {underflow, overflow, invalid_op};
        check_eq("busy_after_start", {31'd0, busy_seen}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("done_single_pulse", {31'd0, done}, 32'd0);
        check_eq("result_held", result, res);
    endtask

    typedef struct {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] exp_res;
        logic [2:0]  exp_flg;   // {underflow, overflow, invalid_op}
        int          exp_lat;
    } vec_t;

    vec_t vecs[17];

    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    int          done_cnt;

    initial begin
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 28};
        vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 28};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 28};
        vecs[3]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 28};
        vecs[4]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, 28};
        vecs[5]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000, 28};
        vecs[6]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, 28};
        vecs[7]  = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 3'b000, 28};
        vecs[8]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b001, 2};
        vecs[9]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 28};
        vecs[10] = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b100, 28};
        vecs[11] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 2};
        vecs[12] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 2};
        vecs[13] = '{32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 2};
        vecs[14] = '{32'h00400000, 32'hC0000000, 32'h80000000, 3'b000, 2};
        vecs[15] = '{32'hFF800000, 32'h80000000, 32'h7FC00000, 3'b001, 2};
        vecs[16] = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b010, 28};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_flags", {29'd0, underflow, overflow, invalid_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].op_a, vecs[i].op_b, res, flg, lat);
            check_eq($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check_eq($sformatf("v%0d_flags", i), {29'd0, flg}, {29'd0, vecs[i].exp_flg});
            check_eq($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // second start during MUL and a start during DONE are both ignored
        @(negedge clk);
        a        = 32'h3FC00000;
        b        = 32'h40000000;
        start    = 1'b1;
        done_cnt = 0;
        lat      = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
            if (lat == 6) begin
                a     = 32'h7F000000;
                b     = 32'h7F000000;
                start = 1'b1;
            end
            if (done) begin
                done_cnt++;
                check_eq("busy_in_done", {31'd0, busy}, 32'd1);
                a     = 32'h00000000;
                b     = 32'h7F800000;
                start = 1'b1;
                @(posedge clk);
                #1;
                lat++;
                start = 1'b0;
                check_eq("start_in_done_ignored", {31'd0, busy}, 32'd0);
            end
        end
        check_eq("busy_done_count", done_cnt, 1);
        check_eq("busy_result", result, 32'h40400000);
        check_eq("busy_flags", {29'd0, underflow, overflow, invalid_op}, 32'd0);

        // reset at E0+10 aborts the operation
        @(negedge clk);
        a     = 32'h3FC00000;
        b     = 32'h3FC00000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_result", result, 32'd0);
        check_eq("abort_flags", {29'd0, underflow, overflow, invalid_op}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check_eq("abort_no_done", done_cnt, 0);

        // normal operation after the abort
        run_op(32'hC0000000, 32'h40400000, res, flg, lat);
        check_eq("post_abort_result", res, 32'hC0C00000);
        check_eq("post_abort_flags", {29'd0, flg}, 32'd0);
        check_eq("post_abort_latency", lat, 28);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
